// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between EX and aux paths.
// Define ALU_ARB_B2B_EN to re-arbitrate on the response handshake cycle.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             own_q, own_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic arb_en;
  logic win;
  logic take;
  logic rsp_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    rsp_hs  = (state_q == RESP) &&
              (own_q ? rsp1_ready : rsp0_ready);
`ifdef ALU_ARB_B2B_EN
    arb_en  = (state_q == IDLE) || rsp_hs;
`else
    arb_en  = (state_q == IDLE);
`endif
    // Tie goes to rr_q; a lone requester always wins.
    win     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    take    = rst_n && arb_en && (req0_valid || req1_valid);
    unique case (state_q)
      IDLE: state_d = IDLE;
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take) begin
      a_d     = win ? req1_a  : req0_a;
      b_d     = win ? req1_b  : req0_b;
      op_d    = win ? req1_op : req0_op;
      own_d   = win;
      rr_d    = ~win;
      state_d = EXEC;
    end
  end

  always_comb begin
    req0_ready = take && !win;
    req1_ready = take && win;
    rsp0_valid = (state_q == RESP) && !own_q;
    rsp1_valid = (state_q == RESP) && own_q;
    rsp_result = res_q;
    rsp_zero   = zero_q;
    alu_a      = a_q;
    alu_b      = b_q;
    alu_op     = op_q;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed literal cases plus a random run
// against a transaction-level model.
module tb_alu_share_arb;
  localparam int W = 32;
`ifdef ALU_ARB_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rv = '0;
  logic [1:0]   rdy;
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic [2:0]   rop [2];
  logic [1:0]   pv;
  logic [1:0]   prd = '0;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic         rsp_zero, alu_zero;
  logic [2:0]   alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b110: return a - b;
      3'b111: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic logic zero_fn(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return d == '0;
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero   = zero_fn(alu_a, alu_b);

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy[0]),
    .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]),
    .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
    .rsp0_valid(pv[0]), .rsp0_ready(prd[0]),
    .rsp1_valid(pv[1]), .rsp1_ready(prd[1]),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: one live op, aged in cycles since its grant.
  bit           m_live;
  int           m_age;
  bit           m_own;
  bit           m_last;
  logic [W-1:0] m_a, m_b, m_res;
  logic [2:0]   m_op;
  logic         m_zero;

  task automatic model_reset();
    m_live = 0; m_age = 0; m_own = 0; m_last = 1;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 0;
  endtask

  task automatic model_cycle();
    bit       resp_now, done, free_now, w;
    logic [1:0] g;
    resp_now = m_live && m_age >= 2;
    done     = resp_now && prd[m_own];
    free_now = !m_live || (B2B && done);
    w = (rv[0] && rv[1]) ? ~m_last : rv[1];
    g = '0;
    if (free_now && (rv != 2'b00)) g[w] = 1'b1;
    check("req_ready", 64'(rdy), 64'(g));
    check("rsp_valid", 64'(pv),
          resp_now ? (m_own ? 64'd2 : 64'd1) : 64'd0);
    check("rsp_result", 64'(rsp_result), 64'(m_res));
    check("rsp_zero", 64'(rsp_zero), 64'(m_zero));
    check("alu_in", {alu_a, alu_b[28:0], alu_op},
          {m_a, m_b[28:0], m_op});
    if (g != 2'b00) begin
      m_live = 1; m_age = 1; m_own = w; m_last = w;
      m_a = ra[w]; m_b = rb[w]; m_op = rop[w];
    end else if (done) begin
      m_live = 0;
    end else if (m_live && m_age == 1) begin
      m_age  = 2;
      m_res  = alu_fn(m_a, m_b, m_op);
      m_zero = zero_fn(m_a, m_b);
    end
  endtask

  task automatic run_one(input int who, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] er, input logic ez);
    int n;
    @(negedge clk);
    rv[who] = 1'b1; ra[who] = a; rb[who] = b; rop[who] = op;
    #1;
    n = 0;
    while (!rdy[who] && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("one_grant", 64'(rdy[who]), 64'd1);
    @(negedge clk);
    rv[who] = 1'b0;
    #1;
    check("one_alu_a", 64'(alu_a), 64'(a));
    check("one_alu_op", 64'(alu_op), 64'(op));
    @(negedge clk); #1;
    check("one_rsp_valid", 64'(pv), who ? 64'd2 : 64'd0 + 64'd1 * (who == 0));
    check("one_result", 64'(rsp_result), 64'(er));
    check("one_zero", 64'(rsp_zero), 64'(ez));
  endtask

  initial begin
    int ng, n, k;
    logic [3:0] gseq;
    int tv [4];
    logic [W-1:0] rr_res [4];
    logic [1:0] acc;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prd = 2'b11;
    #1;
    check("reset_valid", {60'd0, rdy, pv}, 64'd0);
    check("reset_result", {31'd0, rsp_result, rsp_zero}, 64'd0);
    check("reset_alu", {alu_a, alu_b[28:0], alu_op}, 64'd0);

    run_one(0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0);
    run_one(1, 32'd3, 32'd3, 3'b110, 32'd0, 1'b1);
    run_one(1, 32'd2, 32'd9, 3'b111, 32'd1, 1'b0);

    // Dual continuous requests: grants alternate starting with 0.
    @(negedge clk);
    rv = 2'b11;
    ra[0] = 1; rb[0] = 1; rop[0] = 3'b010;
    ra[1] = 8; rb[1] = 2; rop[1] = 3'b110;
    ng = 0; gseq = '0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rdy != 2'b00 && ng < 4) begin
        gseq[ng] = rdy[1]; ng++;
      end
      check("fair_onehot", 64'(rdy == 2'b11), 64'd0);
      if (pv[0]) check("fair_r0", 64'(rsp_result), 64'd2);
      if (pv[1]) check("fair_r1", 64'(rsp_result), 64'd6);
    end
    check("fair_count", 64'(ng), 64'd4);
    check("fair_order", 64'(gseq), 64'b1010);
    @(negedge clk);
    rv = 2'b00;
    repeat (5) @(negedge clk);

    // Single streaming requester: 4 adds k+1.
    k = 0; n = 0; acc = '0;
    rv[0] = 1'b1; ra[0] = 0; rb[0] = 1; rop[0] = 3'b010;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (acc[0]) begin
        k++;
        if (k > 3) rv[0] = 1'b0;
        else ra[0] = W'(k);
      end
      #1;
      acc[0] = rv[0] & rdy[0];
      if (pv[0] && n < 4) begin
        tv[n] = c; rr_res[n] = rsp_result; n++;
      end
    end
    check("stream_count", 64'(n), 64'd4);
    for (int j = 0; j < 4; j++)
      check("stream_result", 64'(rr_res[j]), 64'(j + 1));
    for (int j = 1; j < 4; j++)
      check("stream_gap", 64'(tv[j] - tv[j-1]), B2B ? 64'd2 : 64'd3);

    // Reset during EXEC drops the op.
    @(negedge clk);
    rv = 2'b01; ra[0] = 9; rb[0] = 4; rop[0] = 3'b010;
    #1;
    check("rst_grant", 64'(rdy), 64'd1);
    @(negedge clk);
    rv = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", {60'd0, rdy, pv}, 64'd0);
    check("rst_result", {31'd0, rsp_result, rsp_zero}, 64'd0);
    check("rst_alu", {alu_a, alu_b[28:0], alu_op}, 64'd0);
    @(negedge clk);
    rv = 2'b11;
    #1;
    check("rst_rr", 64'(rdy), 64'd1);
    @(negedge clk);
    rv = 2'b00; rst_n = 1'b0;
    model_reset();
    acc = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) rv[i] = 1'b0;
        if (!rv[i] && $urandom_range(2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = $urandom_range(1) ? W'($urandom) : W'($urandom_range(15));
          rb[i] = ($urandom_range(3) == 0) ? ra[i] : W'($urandom_range(15));
          rop[i] = 3'($urandom_range(7));
        end
        prd[i] = ($urandom_range(3) != 0);
      end
      rst_n = ($urandom_range(79) != 0);
      #1;
      acc = '0;
      if (!rst_n) begin
        model_reset();
      end else begin
        acc = rv & rdy;
        model_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
